// File: rtl/pwm_ctrl.sv
// pwm_ctrl: PWM timebase controller with IDLE/RUN/DRAIN sequencing and shadowed configuration
// that loads at counter wrap. Optional tick prescaler is built when PWM_CTRL_PRESCALE_EN is defined.
module pwm_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_req,
    input  logic        cfg_commit,
    input  logic [15:0] cfg_period,
    input  logic [15:0] cfg_compare1,
    input  logic [15:0] cfg_compare2,
    input  logic [7:0]  cfg_functions,
    input  logic [7:0]  cfg_prescale,
    output logic        pwm_en,
    output logic [15:0] period,
    output logic [15:0] compare1,
    output logic [15:0] compare2,
    output logic [7:0]  functions,
    output logic [15:0] count_val,
    output logic        overflow,
    output logic        commit_ack,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        running;
    logic        tick;
    logic        wrap;
    logic        load;
    logic        pending_q;
    logic        pending_d;
    logic [15:0] count_d;

    assign running = (state_q != IDLE);

`ifdef PWM_CTRL_PRESCALE_EN
    logic [7:0] presc_q;
    logic [7:0] presc_d;
    logic       enter_run;

    // >= rather than == so a prescale value lowered mid-run cannot strand the divider.
    assign tick      = running && (presc_q >= cfg_prescale);
    assign enter_run = (state_d == RUN) && (state_q != RUN);

    always_comb begin
        presc_d = presc_q;
        if (state_d == IDLE || enter_run || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^cfg_prescale;
    assign tick            = running;
`endif

    // Active registers only change in IDLE (count is 0) or on a wrap, so count never exceeds period.
    assign wrap      = tick && (count_val == period);
    assign load      = (pending_q || cfg_commit) && (!running || wrap);
    assign pending_d = (pending_q || cfg_commit) && !load;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d = state_q;
        count_d = count_val;

        case (state_q)
            IDLE: begin
                if (run_req) state_d = RUN;
            end
            RUN: begin
                if (!run_req) state_d = wrap ? IDLE : DRAIN;
            end
            DRAIN: begin
                if (run_req)   state_d = RUN;
                else if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (!running) begin
            count_d = '0;
        end else if (tick) begin
            count_d = wrap ? 16'd0 : count_val + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_val  <= '0;
            period     <= 16'hFFFF;
            compare1   <= '0;
            compare2   <= '0;
            functions  <= '0;
            pending_q  <= 1'b0;
            overflow   <= 1'b0;
            commit_ack <= 1'b0;
            pwm_en     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_val  <= count_d;
            pending_q  <= pending_d;
            overflow   <= wrap;
            commit_ack <= load;
            pwm_en     <= (state_d != IDLE);
            busy       <= (state_d != IDLE);
            if (load) begin
                period    <= cfg_period;
                compare1  <= cfg_compare1;
                compare2  <= cfg_compare2;
                functions <= cfg_functions;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ctrl.sv
// Self-checking bench for pwm_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the IDLE/RUN/DRAIN timebase and its shadowed configuration.
module tb_pwm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_req;
    logic        cfg_commit;
    logic [15:0] cfg_period;
    logic [15:0] cfg_compare1;
    logic [15:0] cfg_compare2;
    logic [7:0]  cfg_functions;
    logic [7:0]  cfg_prescale;
    logic        pwm_en;
    logic [15:0] period;
    logic [15:0] compare1;
    logic [15:0] compare2;
    logic [7:0]  functions;
    logic [15:0] count_val;
    logic        overflow;
    logic        commit_ack;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_active;
    bit          m_draining;
    logic [15:0] m_cnt;
    logic [15:0] m_per;
    logic [15:0] m_c1;
    logic [15:0] m_c2;
    logic [7:0]  m_fn;
    bit          m_pend;
    int          m_presc;
    bit          m_ovf;
    bit          m_ack;

    pwm_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run_req       (run_req),
        .cfg_commit    (cfg_commit),
        .cfg_period    (cfg_period),
        .cfg_compare1  (cfg_compare1),
        .cfg_compare2  (cfg_compare2),
        .cfg_functions (cfg_functions),
        .cfg_prescale  (cfg_prescale),
        .pwm_en        (pwm_en),
        .period        (period),
        .compare1      (compare1),
        .compare2      (compare2),
        .functions     (functions),
        .count_val     (count_val),
        .overflow      (overflow),
        .commit_ack    (commit_ack),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic reset_model();
        m_active   = 0;
        m_draining = 0;
        m_cnt      = 16'd0;
        m_per      = 16'hFFFF;
        m_c1       = 16'd0;
        m_c2       = 16'd0;
        m_fn       = 8'd0;
        m_pend     = 0;
        m_presc    = 0;
        m_ovf      = 0;
        m_ack      = 0;
    endtask

    // One clock of the specified behaviour, evaluated from the inputs presented to this edge.
    task automatic model_step();
        bit tick, wrap, load, nxt_active, nxt_drain, enter_run;
        int nxt_cnt;
`ifdef PWM_CTRL_PRESCALE_EN
        tick = m_active && (m_presc >= int'(cfg_prescale));
`else
        tick = m_active;
`endif
        wrap = tick && (m_cnt == m_per);
        load = (m_pend || cfg_commit) && (!m_active || wrap);

        if (!m_active)   nxt_cnt = 0;
        else if (wrap)   nxt_cnt = 0;
        else if (tick)   nxt_cnt = int'(m_cnt) + 1;
        else             nxt_cnt = int'(m_cnt);

        enter_run = 0;
        nxt_active = m_active;
        nxt_drain  = m_draining;
        if (!m_active) begin
            nxt_active = run_req;
            enter_run  = run_req;
        end else if (run_req) begin
            enter_run = m_draining;
            nxt_drain = 0;
        end else if (wrap) begin
            nxt_active = 0;
            nxt_drain  = 0;
        end else begin
            nxt_drain = 1;
        end

        if (!nxt_active || enter_run || tick) m_presc = 0;
        else                                  m_presc = m_presc + 1;

        if (load) begin
            m_per = cfg_period;
            m_c1  = cfg_compare1;
            m_c2  = cfg_compare2;
            m_fn  = cfg_functions;
        end
        m_pend     = (m_pend || cfg_commit) && !load;
        m_ovf      = wrap;
        m_ack      = load;
        m_cnt      = 16'(nxt_cnt);
        m_active   = nxt_active;
        m_draining = nxt_drain;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [15:0] p, input logic [15:0] c1,
                            input logic [15:0] c2, input logic [7:0] fn);
        cfg_period    = p;
        cfg_compare1  = c1;
        cfg_compare2  = c2;
        cfg_functions = fn;
        cfg_commit    = 1'b1;
        step();
        cfg_commit    = 1'b0;
    endtask

    task automatic start_run();
        run_req = 1'b1;
        step();
    endtask

    task automatic go_idle();
        int n = 0;
        run_req    = 1'b0;
        cfg_commit = 1'b0;
        step();
        while (busy === 1'b1 && n < 300) begin
            step();
            n++;
        end
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL go_idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run_req = 1'b0; cfg_commit = 1'b0; cfg_period = 16'd0;
        cfg_compare1 = 16'd0; cfg_compare2 = 16'd0; cfg_functions = 8'd0; cfg_prescale = 8'd0;
        reset_model();
        #12;
        n_assert++;
        if ({pwm_en, busy, overflow, commit_ack, count_val, period, compare1, compare2, functions}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0, 16'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values: en=%b busy=%b ovf=%b ack=%b cnt=%h per=%h c1=%h c2=%h fn=%h, required 0 0 0 0 0000 ffff 0000 0000 00",
                     pwm_en, busy, overflow, commit_ack, count_val, period, compare1, compare2, functions);
        end
        #11 rst_n = 1'b1;
    endtask

    task automatic test_commit_idle();
        cfg_period = 16'd4; cfg_compare1 = 16'd2; cfg_compare2 = 16'd3; cfg_functions = 8'h5A;
        cfg_prescale = 8'd0;
        cfg_commit = 1'b1;
        run_req    = 1'b1;
        step();
        cfg_commit = 1'b0;
        n_assert++;
        if ({commit_ack, period, compare1, compare2, functions, count_val, pwm_en}
            !== {1'b1, 16'd4, 16'd2, 16'd3, 8'h5A, 16'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL commit_idle_load: ack=%b per=%0d c1=%0d c2=%0d fn=%h cnt=%0d en=%b, required 1 4 2 3 5a 0 1",
                     commit_ack, period, compare1, compare2, functions, count_val, pwm_en);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            n_assert++;
            if (count_val !== 16'(k % 5) || overflow !== (k == 5) || commit_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL commit_idle_seq[%0d]: cnt=%0d ovf=%b ack=%b, required %0d %b 0",
                         k, count_val, overflow, commit_ack, k % 5, (k == 5));
            end
        end
    endtask

    task automatic test_commit_midrun();
        go_idle();
        load_cfg(16'd9, 16'd1, 16'd1, 8'h01);
        start_run();
        repeat (3) step();
        cfg_period = 16'd2; cfg_compare1 = 16'd7; cfg_compare2 = 16'd8; cfg_functions = 8'h22;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        for (int k = 4; k <= 9; k++) begin
            if (k > 4) step();
            n_assert++;
            if (count_val !== 16'(k) || commit_ack !== 1'b0 || period !== 16'd9) begin
                n_fail++;
                $display("FAIL midrun_hold[%0d]: cnt=%0d ack=%b per=%0d, required %0d 0 9",
                         k, count_val, commit_ack, period, k);
            end
        end
        step();
        n_assert++;
        if ({count_val, overflow, commit_ack, period, compare1, functions}
            !== {16'd0, 1'b1, 1'b1, 16'd2, 16'd7, 8'h22}) begin
            n_fail++;
            $display("FAIL midrun_wrap_load: cnt=%0d ovf=%b ack=%b per=%0d c1=%0d fn=%h, required 0 1 1 2 7 22",
                     count_val, overflow, commit_ack, period, compare1, functions);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_assert++;
            if (count_val !== 16'(k % 3) || overflow !== (k == 3) || commit_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_new_period[%0d]: cnt=%0d ovf=%b ack=%b, required %0d %b 0",
                         k, count_val, overflow, commit_ack, k % 3, (k == 3));
            end
        end
    endtask

    task automatic test_drain();
        go_idle();
        load_cfg(16'd5, 16'd0, 16'd0, 8'h00);
        start_run();
        repeat (2) step();
        run_req = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            step();
            n_assert++;
            if (count_val !== 16'(k) || busy !== 1'b1 || pwm_en !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_count[%0d]: cnt=%0d busy=%b en=%b, required %0d 1 1",
                         k, count_val, busy, pwm_en, k);
            end
        end
        step();
        n_assert++;
        if ({count_val, overflow, busy, pwm_en} !== {16'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL drain_exit: cnt=%0d ovf=%b busy=%b en=%b, required 0 1 0 0",
                     count_val, overflow, busy, pwm_en);
        end
        start_run();
        repeat (2) step();
        run_req = 1'b0;
        step();
        run_req = 1'b1;
        step();
        n_assert++;
        if (count_val !== 16'd4 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_resume: cnt=%0d busy=%b, required 4 1", count_val, busy);
        end
        repeat (2) step();
        n_assert++;
        if ({count_val, overflow, busy} !== {16'd0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL drain_resume_wrap: cnt=%0d ovf=%b busy=%b, required 0 1 1",
                     count_val, overflow, busy);
        end
    endtask

    task automatic test_period_zero();
        go_idle();
        load_cfg(16'd0, 16'd0, 16'd0, 8'h00);
        start_run();
        for (int k = 0; k < 6; k++) begin
            step();
            n_assert++;
            if (count_val !== 16'd0 || overflow !== 1'b1) begin
                n_fail++;
                $display("FAIL period_zero[%0d]: cnt=%0d ovf=%b, required 0 1", k, count_val, overflow);
            end
        end
    endtask

    task automatic test_multi_commit();
        int acks = 0;
        int n = 0;
        go_idle();
        load_cfg(16'd20, 16'd0, 16'd0, 8'h00);
        start_run();
        cfg_period = 16'd6;
        repeat (3) begin
            cfg_commit = 1'b1;
            step();
            acks += int'(commit_ack);
            cfg_commit = 1'b0;
            step();
            acks += int'(commit_ack);
        end
        while (overflow !== 1'b1 && n < 40) begin
            step();
            acks += int'(commit_ack);
            n++;
        end
        repeat (14) begin
            step();
            acks += int'(commit_ack);
        end
        n_assert++;
        if (acks !== 1 || period !== 16'd6) begin
            n_fail++;
            $display("FAIL multi_commit: acks=%0d per=%0d, required 1 6", acks, period);
        end
    endtask

    task automatic test_prescale();
        go_idle();
        cfg_prescale = 8'd2;
        load_cfg(16'd1, 16'd0, 16'd0, 8'h00);
        start_run();
        for (int k = 1; k <= 18; k++) begin
            int e_cnt;
            bit e_ovf;
            step();
`ifdef PWM_CTRL_PRESCALE_EN
            e_cnt = (k / 3) % 2;
            e_ovf = (k % 6 == 0);
`else
            e_cnt = k % 2;
            e_ovf = (k % 2 == 0);
`endif
            n_assert++;
            if (count_val !== 16'(e_cnt) || overflow !== e_ovf) begin
                n_fail++;
                $display("FAIL prescale[%0d]: cnt=%0d ovf=%b, required %0d %b",
                         k, count_val, overflow, e_cnt, e_ovf);
            end
        end
        cfg_prescale = 8'd0;
    endtask

    task automatic test_reset_midrun();
        int acks = 0;
        go_idle();
        load_cfg(16'd20, 16'd0, 16'd0, 8'h00);
        start_run();
        repeat (6) step();
        cfg_period = 16'd3; cfg_compare1 = 16'h1234;
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
        n_assert++;
        if (count_val !== 16'd7) begin
            n_fail++;
            $display("FAIL reset_midrun_pre: cnt=%0d, required 7", count_val);
        end
        #2 rst_n = 1'b0;
        reset_model();
        #1;
        n_assert++;
        if ({pwm_en, busy, overflow, commit_ack, count_val, period, compare1}
            !== {1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 16'hFFFF, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_midrun_async: en=%b busy=%b ovf=%b ack=%b cnt=%0d per=%h c1=%h, required 0 0 0 0 0 ffff 0000",
                     pwm_en, busy, overflow, commit_ack, count_val, period, compare1);
        end
        run_req = 1'b0;
        #2 rst_n = 1'b1;
        repeat (20) begin
            step();
            acks += int'(commit_ack);
        end
        n_assert++;
        if (acks !== 0 || period !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_discard_pending: acks=%0d per=%h, required 0 ffff", acks, period);
        end
    endtask

    task automatic test_random();
        logic [75:0] act, exp;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) run_req = ~run_req;
            cfg_commit    = ($urandom_range(0, 11) == 0);
            cfg_period    = 16'($urandom_range(0, 10));
            cfg_compare1  = 16'($urandom);
            cfg_compare2  = 16'($urandom);
            cfg_functions = 8'($urandom);
            cfg_prescale  = 8'($urandom_range(0, 3));
            step();
            act = {pwm_en, busy, count_val, overflow, commit_ack, period, compare1, compare2, functions};
            exp = {m_active, m_active, m_cnt, m_ovf, m_ack, m_per, m_c1, m_c2, m_fn};
            n_assert++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h, required %h", i, act, exp);
            end
            n_assert++;
            if (count_val > period) begin
                n_fail++;
                $display("FAIL random_range[%0d]: cnt=%0d per=%0d, required cnt<=per", i, count_val, period);
            end
        end
        cfg_commit = 1'b0;
    endtask

    initial begin
        test_reset();
        test_commit_idle();
        test_commit_midrun();
        test_drain();
        test_period_zero();
        test_multi_commit();
        test_prescale();
        test_reset_midrun();
        go_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ctrl.md
PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named exactly clk and rst_n.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- run_req  input  1  level; 1 = request counting, 0 = request stop.
- cfg_commit  input  1  single-cycle pulse; request load of the cfg_* values into the active registers.
- cfg_period  input  16  requested period.
- cfg_compare1  input  16  requested compare1.
- cfg_compare2  input  16  requested compare2.
- cfg_functions  input  8  requested mode byte.
- cfg_prescale  input  8  tick divider; a tick occurs every cfg_prescale+1 clocks.
- pwm_en  output  1  enable for the PWM generator.
- period, compare1, compare2  output  16 each  active (shadowed) configuration.
- functions  output  8  active mode byte.
- count_val  output  16  current counter value.
- overflow  output  1  one-clock pulse at counter wrap.
- commit_ack  output  1  one-clock pulse when the active registers load.
- busy  output  1  1 in RUN or DRAIN.

Function
REQ-003 The FSM SHALL have the states IDLE, RUN and DRAIN.
REQ-004 IDLE->RUN SHALL occur on the first clock with run_req=1; count_val SHALL be 0 on entry to RUN.
REQ-005 In RUN, a tick SHALL increment count_val by 1; when count_val==period, the tick SHALL instead wrap count_val to 0 and assert overflow on that same clock edge.
REQ-006 RUN->DRAIN SHALL occur when run_req=0; DRAIN SHALL keep counting until the next wrap, then go to IDLE with count_val=0.
REQ-007 If run_req returns to 1 while in DRAIN, the FSM SHALL return to RUN without resetting count_val.
REQ-008 pwm_en SHALL be 1 exactly in RUN and DRAIN (registered; equals busy).
REQ-009 A cfg_commit pulse SHALL set a pending flag; in IDLE the load SHALL occur on the next clock, and in RUN or DRAIN it SHALL occur on the wrap edge.
REQ-010 A load SHALL copy the cfg_* values present on that edge into period, compare1, compare2 and functions, SHALL clear pending, and SHALL pulse commit_ack for one clock.
REQ-011 Further cfg_commit pulses while pending is set SHALL be absorbed: one load and one commit_ack only.
REQ-012 If cfg_commit coincides with a wrap edge, the load SHALL occur on that edge.
REQ-013 If period==0, every tick SHALL wrap: count_val stays 0 and overflow pulses once per tick.
REQ-014 If a load changes period to a value below the current count_val, the change SHALL take effect only after the wrap, so no out-of-range count is possible.
REQ-015 count_val arithmetic SHALL be 16-bit unsigned; count_val SHALL never exceed the active period.
REQ-016 Outputs SHALL change only on clock edges; overflow and commit_ack SHALL each be high for exactly one clock per event.

Reset
REQ-017 On rst_n=0, the block SHALL asynchronously force: state=IDLE, count_val=0, period=16'hFFFF, compare1=0, compare2=0, functions=0, pending=0, prescaler=0, and all outputs (pwm_en, overflow, commit_ack, busy) =0.
REQ-018 Reset asserted mid-RUN SHALL abort immediately and discard any pending commit.

Configuration
REQ-019 With PWM_CTRL_PRESCALE_EN defined, an 8-bit prescaler SHALL generate a tick each time it reaches cfg_prescale and then clear; the prescaler SHALL clear on entry to RUN.
REQ-020 Without PWM_CTRL_PRESCALE_EN, every clock SHALL be a tick and cfg_prescale SHALL be ignored.

Verification
REQ-021 Commit in IDLE: cfg_period=4, cfg_commit pulse, run_req=1, prescale=0 -> commit_ack one clock later; count_val sequence 0,1,2,3,4,0; overflow on the 4->0 edge.
REQ-022 Commit mid-run: period=9, count_val=3, commit cfg_period=2 -> count continues to 9, wraps, commit_ack on the wrap edge, then 0,1,2,0.
REQ-023 Drain: period=5, drop run_req at count 2 -> count reaches 5, wraps, IDLE, pwm_en=0; raise run_req during DRAIN -> stays RUN, no count reset.
REQ-024 Prescale (macro defined): cfg_prescale=2, period=1 -> count_val changes every 3 clocks; overflow every 6 clocks.
REQ-025 Edge cases: period=0 -> overflow every tick; three cfg_commit pulses in one period -> single commit_ack.
REQ-026 Reset mid-RUN at count 7 with commit pending -> all outputs 0, period=16'hFFFF, no commit_ack after reset release.
